// File: rtl/board_disp_sched.sv
// board_disp_sched: debounced page/freeze scheduler for the DE2 debug hex digits; BOARD_DISP_AUTO_ROTATE_EN adds timed page rotation.
module board_disp_sched #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ROTATE_CYCLES   = 150000000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_key_next_n,
  input  logic        i_key_hold_n,
  input  logic [15:0] i_nes_cpu_pc,
  input  logic [7:0]  i_nes_cpu_sp,
  input  logic [7:0]  i_nes_cpu_ir,
  input  logic [7:0]  i_nes_cpu_p,
  input  logic [7:0]  i_nes_cpu_a,
  input  logic [7:0]  i_nes_cpu_x,
  input  logic [7:0]  i_nes_cpu_y,
  output logic [31:0] o_hex_digits,
  output logic [1:0]  o_page,
  output logic        o_frozen,
  output logic        o_page_tick
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  typedef enum logic [1:0] {IDLE, ARM_PRESS, PRESSED, ARM_REL} db_e;
  if (DEBOUNCE_CYCLES < 2 || ROTATE_CYCLES < 2) begin : g_bad_param
    $error("board_disp_sched: DEBOUNCE_CYCLES and ROTATE_CYCLES must be >= 2");
  end
  logic [1:0] raw, pulse;
  assign raw = {i_key_hold_n, i_key_next_n};
  genvar k;
  for (k = 0; k < 2; k++) begin : g_db
    logic s1_q, s2_q, hit, p;
    db_e st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    // The count is checked one short so the pulse is seen on the edge the counter would reach the limit.
    always_comb begin
      hit = cnt_q == CW'(DEBOUNCE_CYCLES - 2);
      st_d = st_q;
      cnt_d = cnt_q;
      p = 1'b0;
      case (st_q)
        IDLE:      if (!s2_q) begin st_d = ARM_PRESS; cnt_d = '0; end
        ARM_PRESS: if (s2_q) st_d = IDLE;
                   else if (hit) begin st_d = PRESSED; p = 1'b1; end
                   else cnt_d = cnt_q + 1'b1;
        PRESSED:   if (s2_q) begin st_d = ARM_REL; cnt_d = '0; end
        ARM_REL:   if (!s2_q) st_d = PRESSED;
                   else if (hit) st_d = IDLE;
                   else cnt_d = cnt_q + 1'b1;
      endcase
    end
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        s1_q <= 1'b1;
        s2_q <= 1'b1;
        st_q <= IDLE;
        cnt_q <= '0;
      end else begin
        s1_q <= raw[k];
        s2_q <= s1_q;
        st_q <= st_d;
        cnt_q <= cnt_d;
      end
    end
    assign pulse[k] = p;
  end
  logic next, hold, rot_exp;
  assign next = pulse[0];
  assign hold = pulse[1];
  logic frozen_q, frozen_d, tick_q, tick_d, adv;
  logic [1:0] page_q, page_d;
  logic [63:0] live, snap_q, snap_d, src;
  logic [31:0] hex_q, hex_d, flags;
`ifdef BOARD_DISP_AUTO_ROTATE_EN
  localparam int RW = $clog2(ROTATE_CYCLES);
  logic [RW-1:0] rot_q, rot_d;
  always_comb begin
    rot_exp = !frozen_q && rot_q == RW'(ROTATE_CYCLES - 1);
    rot_d = (next || rot_exp) ? '0 : frozen_q ? rot_q : rot_q + 1'b1;
  end
  always_ff @(posedge i_clk) rot_q <= i_rst ? '0 : rot_d;
`else
  assign rot_exp = 1'b0;
`endif
  assign live = {i_nes_cpu_pc, i_nes_cpu_sp, i_nes_cpu_ir, i_nes_cpu_a, i_nes_cpu_x, i_nes_cpu_y, i_nes_cpu_p};
  always_comb begin
    adv = next || rot_exp;
    page_d = (page_q == 2'd3) ? 2'd0 : adv ? ((page_q == 2'd2) ? 2'd0 : page_q + 2'd1) : page_q;
    tick_d = page_d != page_q;
    frozen_d = frozen_q ^ hold;
    snap_d = (hold && !frozen_q) ? live : snap_q;
    src = frozen_q ? snap_q : live;
    flags = '0;
    for (int i = 0; i < 8; i++) flags[4*i +: 4] = {3'b000, src[i]};
    hex_d = (page_q == 2'd0) ? src[63:32] : (page_q == 2'd1) ? src[31:0] : (page_q == 2'd2) ? flags : '0;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      page_q <= '0;
      tick_q <= 1'b0;
      frozen_q <= 1'b0;
      snap_q <= '0;
      hex_q <= '0;
    end else begin
      page_q <= page_d;
      tick_q <= tick_d;
      frozen_q <= frozen_d;
      snap_q <= snap_d;
      hex_q <= hex_d;
    end
  end
  assign o_hex_digits = hex_q;
  assign o_page = page_q;
  assign o_frozen = frozen_q;
  assign o_page_tick = tick_q;
endmodule

// File: tb/tb_board_disp_sched.sv
// tb_board_disp_sched: directed test of paging, debounce timing, freeze and reset-mid-press.
module tb_board_disp_sched;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1, kn = 1'b1, kh = 1'b1;
  logic [15:0] pc = 16'hC000;
  logic [7:0] sp = 8'hFD, ir = 8'h4C, p = 8'h24, a = 8'h12, x = 8'h34, y = 8'h56;
  logic [31:0] hex;
  logic [1:0] page;
  logic frozen, ptick;
  int errs = 0, checks = 0, nticks = 0, at_tick = 0;
  logic fz_at = 1'b0;
  board_disp_sched #(.DEBOUNCE_CYCLES(4), .ROTATE_CYCLES(20)) dut (
    .i_clk(clk), .i_rst(rst), .i_key_next_n(kn), .i_key_hold_n(kh),
    .i_nes_cpu_pc(pc), .i_nes_cpu_sp(sp), .i_nes_cpu_ir(ir), .i_nes_cpu_p(p),
    .i_nes_cpu_a(a), .i_nes_cpu_x(x), .i_nes_cpu_y(y),
    .o_hex_digits(hex), .o_page(page), .o_frozen(frozen), .o_page_tick(ptick)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run(input int n);
    for (int i = 1; i <= n; i++) begin
      step();
      if (ptick) begin
        nticks++;
        at_tick = i;
        fz_at = frozen;
      end
    end
  endtask
  task automatic press(input bit nx, input bit hd);
    nticks = 0;
    kn = ~nx;
    kh = ~hd;
    run(10);
    kn = 1'b1;
    kh = 1'b1;
    run(10);
  endtask
  initial begin
    repeat (3) step();
    check("rst_hex", hex, 32'h0);
    check("rst_page", page, 2'd0);
    check("rst_frozen", frozen, 1'b0);
    check("rst_tick", ptick, 1'b0);
    rst = 1'b0;
    step();
    check("live_p0_hex", hex, 32'hC000FD4C);
    check("live_p0_page", page, 2'd0);
    nticks = 0;
    kn = 1'b0;
    run(10);
    check("next_ticks", nticks, 1);
    check("next_latency", at_tick, 6);
    check("next_page", page, 2'd1);
    check("p1_hex", hex, 32'h12345624);
    kn = 1'b1;
    run(10);
    check("release_no_tick", nticks, 1);
    nticks = 0;
    for (int i = 0; i < 20; i++) begin
      kn = (i / 2) % 2 == 1;
      run(1);
    end
    kn = 1'b1;
    run(10);
    check("bounce_ticks", nticks, 0);
    check("bounce_page", page, 2'd1);
    p = 8'hA5;
    press(1'b1, 1'b0);
    check("p2_ticks", nticks, 1);
    check("p2_page", page, 2'd2);
    check("p2_hex", hex, 32'h10100101);
    press(1'b1, 1'b0);
    check("wrap_page", page, 2'd0);
    pc = 16'h8000;
    step();
    press(1'b0, 1'b1);
    check("hold_ticks", nticks, 0);
    pc = 16'h9000;
    step();
    step();
    check("freeze_on", frozen, 1'b1);
    check("freeze_hex", hex, 32'h8000FD4C);
    press(1'b0, 1'b1);
    check("freeze_off", frozen, 1'b0);
    check("unfreeze_hex", hex, 32'h9000FD4C);
    press(1'b1, 1'b1);
    check("both_ticks", nticks, 1);
    check("both_frozen_at_tick", fz_at, 1'b1);
    check("both_page", page, 2'd1);
    a = 8'hFF;
    step();
    step();
    check("both_snap_hex", hex, 32'h123456A5);
    kn = 1'b0;
    run(3);
    rst = 1'b1;
    step();
    step();
    check("midrst_page", page, 2'd0);
    check("midrst_frozen", frozen, 1'b0);
    rst = 1'b0;
    nticks = 0;
    run(10);
    check("midrst_ticks", nticks, 1);
    check("midrst_latency", at_tick, 6);
    check("midrst_hex", hex, 32'hFF3456A5);
    kn = 1'b1;
    run(10);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/board_disp_sched.md
Name: board_disp_sched

Overview:
Display scheduler for the DE2 board debug lights. It selects which NES CPU debug page drives the eight seven-segment digits, and it debounces two board pushbuttons. The "next" button steps through the pages. The "hold" button freezes a snapshot of the CPU state. Its 32-bit digit word feeds eight hex-to-segment decoders, where nibble [31:28] drives HEX0 and nibble [3:0] drives HEX7.

Parameters:
DEBOUNCE_CYCLES, 500000, number of cycles a synchronized key level must stay stable to be accepted (10 ms at 50 MHz); legal range ≥2.
ROTATE_CYCLES, 150000000, auto-rotate period in cycles; used only with the optional feature; legal range ≥2.

Ports:
i_clk  in  1  system clock
i_rst  in  1  synchronous reset, active-high
i_key_next_n  in  1  raw pushbutton, active-low, asynchronous to i_clk
i_key_hold_n  in  1  raw pushbutton, active-low, asynchronous to i_clk
i_nes_cpu_pc  in  16  CPU program counter
i_nes_cpu_sp  in  8  CPU stack pointer
i_nes_cpu_ir  in  8  CPU instruction register
i_nes_cpu_p  in  8  CPU status register
i_nes_cpu_a  in  8  CPU accumulator
i_nes_cpu_x  in  8  CPU X register
i_nes_cpu_y  in  8  CPU Y register
o_hex_digits  out  32  eight display nibbles, registered
o_page  out  2  current page index
o_frozen  out  1  1 = display shows the snapshot
o_page_tick  out  1  one-cycle pulse in the cycle o_page changes

Behaviour:
- Reset (i_rst=1 sampled at a clock edge):
  - o_hex_digits=0, o_page=0, o_frozen=0, o_page_tick=0.
  - Snapshot registers = 0; all counters = 0.
  - Key synchronizer flops = 1 (released); both debouncers in IDLE.
- Synchronizer: 2 flops per key. Debouncing operates on the synchronized level only.
- Debouncer FSM, one instance per key, with a shared counter width of $clog2(DEBOUNCE_CYCLES):
  - IDLE: if the level is 0, clear the counter and go to ARM_PRESS.
  - ARM_PRESS: while the level is 0, count. If the level returns to 1, go to IDLE. When the counter reaches DEBOUNCE_CYCLES-1, go to PRESSED and emit a one-cycle press pulse.
  - PRESSED: if the level is 1, clear the counter and go to ARM_REL.
  - ARM_REL: while the level is 1, count. If the level returns to 0, go to PRESSED with no new pulse. When the counter reaches DEBOUNCE_CYCLES-1, go to IDLE.
  - A clean raw press produces its pulse exactly DEBOUNCE_CYCLES+2 cycles after the raw falling edge.
  - One pulse per physical press. Holding the key never repeats.
- Page FSM:
  - Each next pulse advances PAGE_CPU(0) -> PAGE_REGS(1) -> PAGE_FLAGS(2) -> PAGE_CPU(0).
  - Encoding 3 is illegal and recovers to 0 on the next cycle.
  - o_page_tick=1 in the same cycle o_page is updated.
- Page content, where the source is either the live inputs or the snapshot:
  - Page 0: {pc[15:0], sp, ir}.
  - Page 1: {a, x, y, p}.
  - Page 2: nibble k (k=7 is the MSB nibble) = {3'b000, p[k]}, so HEX0 shows N and HEX7 shows C.
- Freeze:
  - Each hold pulse toggles o_frozen.
  - On a 0->1 toggle, all seven CPU inputs are captured into the snapshot at that edge.
  - While o_frozen=1, the selected page renders from the snapshot and page stepping still works.
  - On a 1->0 toggle, live data is shown again.
- Output latency:
  - o_hex_digits is registered and reflects the inputs, page and frozen state of the previous cycle.
  - A page change is therefore visible one cycle after o_page_tick.
- Simultaneous next and hold pulses: both take effect in the same cycle. The snapshot holds the current inputs and the page advances.
- Reset asserted mid-press: all state is discarded. A key still held low at reset release is accepted as a new press after DEBOUNCE_CYCLES+2 cycles.

Optional Feature:
BOARD_DISP_AUTO_ROTATE_EN
- Defined:
  - A rotate counter of width $clog2(ROTATE_CYCLES) increments every cycle while o_frozen=0.
  - When it reaches ROTATE_CYCLES-1, the page advances exactly as for a next pulse, o_page_tick pulses, and the counter returns to 0.
  - A next pulse also clears the counter.
  - A rotate expiry and a next pulse in the same cycle advance the page by one step only.
  - The counter holds its value while frozen and resets to 0 on i_rst.
- Undefined: no rotate counter is built, and the page changes only on next pulses.

Test Plan:
- Sim parameters: DEBOUNCE_CYCLES=4, ROTATE_CYCLES=20. pc=16'hC000, sp=8'hFD, ir=8'h4C, i_rst held 3 cycles -> o_hex_digits=32'hC000FD4C one cycle after reset release; o_page=0.
- i_key_next_n low for 10 cycles -> o_page_tick pulses once, exactly 6 cycles after the falling edge; o_page=1; digits = {a,x,y,p}. With a=8'h12, x=8'h34, y=8'h56, p=8'h24 -> 32'h12345624.
- i_key_next_n toggling every 2 cycles for 20 cycles -> no page change; o_page_tick stays 0.
- Page 2 with p=8'hA5 -> o_hex_digits=32'h10100101.
- Hold press with pc=16'h8000, then pc driven to 16'h9000 -> page 0 digits keep 8000 and o_frozen=1. A second hold press -> o_frozen=0 and digits show 9000.
- next and hold pulses aligned in the same cycle -> o_page advances and o_frozen=1 in that cycle. With BOARD_DISP_AUTO_ROTATE_EN, 20 idle cycles -> one page advance, and no advance while frozen.
